// File: rtl/rally_ctrl_pkg.sv
// Shared definitions for the rally controller: FSM state encoding, player ids,
// touch counter width and the win-condition helper.
package rally_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_RALLY      = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_e;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam int unsigned TOUCH_W = 2;

  // Scorer wins once it has reached the target score with the required lead.
  function automatic logic is_win(input int unsigned mine,
                                  input int unsigned other,
                                  input int unsigned win_score,
                                  input int unsigned margin);
    return (mine >= win_score) && (mine >= other + margin);
  endfunction

endpackage

// File: rtl/rally_ctrl_touch_counter.sv
// Touch counter for the rally controller.
// Rising-edge detects the two player collision levels, tracks which side
// touched last and how many consecutive touches that side has made, and flags
// a fault when a side touches once more than MAX_TOUCHES allows.
// Ports:
//   pclk, rst          clock, synchronous active-high reset
//   en                 count touches (rally in progress)
//   clr                clear the consecutive-touch count (new serve)
//   block              suppress touches this cycle (ground contact wins)
//   pl1_col, pl2_col   player collision levels
//   last_touch         side of the last counted touch (registered)
//   touch_cnt          consecutive touches by last_touch side (registered)
//   fault              one-cycle fault pulse (registered)
//   fault_c            fault condition in the current cycle, for the FSM
module rally_ctrl_touch_counter
  import rally_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TOUCHES = 3
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               block,
  input  logic               pl1_col,
  input  logic               pl2_col,
  output logic               last_touch,
  output logic [TOUCH_W-1:0] touch_cnt,
  output logic               fault,
  output logic               fault_c
);

  localparam logic [TOUCH_W-1:0] CNT_LIMIT = TOUCH_W'(MAX_TOUCHES);

  logic               pl1_q;
  logic               pl2_q;
  logic               pl1_edge;
  logic               pl2_edge;
  logic               touch_side;
  logic               last_touch_nxt;
  logic [TOUCH_W-1:0] touch_cnt_nxt;

  assign pl1_edge   = pl1_col & ~pl1_q;
  assign pl2_edge   = pl2_col & ~pl2_q;
  assign touch_side = pl2_edge;

  // Touch bookkeeping; simultaneous touches from both sides are a net block.
  always_comb begin
    last_touch_nxt = last_touch;
    touch_cnt_nxt  = touch_cnt;
    fault_c        = 1'b0;
    if (clr) begin
      touch_cnt_nxt = '0;
    end else if (en && !block && (pl1_edge ^ pl2_edge)) begin
      if (touch_side == last_touch) begin
        if (touch_cnt == CNT_LIMIT) begin
          fault_c = 1'b1;
        end else begin
          touch_cnt_nxt = touch_cnt + TOUCH_W'(1);
        end
      end else begin
        last_touch_nxt = touch_side;
        touch_cnt_nxt  = TOUCH_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pl1_q      <= 1'b0;
      pl2_q      <= 1'b0;
      last_touch <= 1'b0;
      touch_cnt  <= '0;
      fault      <= 1'b0;
    end else begin
      pl1_q      <= pl1_col;
      pl2_q      <= pl2_col;
      last_touch <= last_touch_nxt;
      touch_cnt  <= touch_cnt_nxt;
      fault      <= fault_c;
    end
  end

endmodule

// File: rtl/rally_ctrl.sv
// Match controller for the volley game: rally FSM, serve delay, score
// registers, win comparator and serve hand-over.
// Build option: RALLY_CTRL_SIDE_OUT_EN selects side-out scoring (only the
// server scores, a receiver rally win hands over the serve). Without it,
// rally-point scoring is used (rally winner scores and takes the serve).
// Ports:
//   pclk, rst                 clock, synchronous active-high reset
//   start                     start/restart pulse (IDLE and GAME_OVER only)
//   gnd_col, ball_side        ground contact level and the half it happened in
//   pl1_col, pl2_col          player collision levels
//   score_pl1, score_pl2      scores
//   serve_req, serve_side     serve re-spawn pulse and serving side
//   last_touch, touch_cnt     touch tracking
//   fault                     touch-limit fault pulse
//   game_active, endgame      match running / match finished
//   winner                    winning side, valid while endgame
module rally_ctrl
  import rally_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 15,
  parameter int unsigned WIN_MARGIN  = 2,
  parameter int unsigned MAX_TOUCHES = 3,
  parameter int unsigned SERVE_DLY   = 65000000
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               start,
  input  logic               gnd_col,
  input  logic               ball_side,
  input  logic               pl1_col,
  input  logic               pl2_col,
  output logic [SCORE_W-1:0] score_pl1,
  output logic [SCORE_W-1:0] score_pl2,
  output logic               serve_req,
  output logic               serve_side,
  output logic               last_touch,
  output logic [TOUCH_W-1:0] touch_cnt,
  output logic               fault,
  output logic               game_active,
  output logic               endgame,
  output logic               winner
);

  localparam int unsigned        CNT_W     = $clog2(SERVE_DLY + 1);
  localparam logic [CNT_W-1:0]   DLY_LAST  = CNT_W'(SERVE_DLY - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   dly_cnt;
  logic [CNT_W-1:0]   dly_cnt_nxt;
  logic [SCORE_W-1:0] score_pl1_nxt;
  logic [SCORE_W-1:0] score_pl2_nxt;
  logic               serve_req_nxt;
  logic               serve_side_nxt;
  logic               game_active_nxt;
  logic               endgame_nxt;
  logic               winner_nxt;
  logic               point_to;
  logic               point_to_nxt;
  logic               gnd_q;
  logic               gnd_edge_c;
  logic               touch_clr_c;
  logic               fault_c;
  logic [SCORE_W-1:0] mine_c;
  logic [SCORE_W-1:0] other_c;
  logic [SCORE_W-1:0] mine_inc_c;
  logic               won_c;

  assign gnd_edge_c = gnd_col & ~gnd_q;

  rally_ctrl_touch_counter #(
    .MAX_TOUCHES (MAX_TOUCHES)
  ) u_touch (
    .pclk       (pclk),
    .rst        (rst),
    .en         (state == ST_RALLY),
    .clr        (touch_clr_c),
    .block      (gnd_edge_c),
    .pl1_col    (pl1_col),
    .pl2_col    (pl2_col),
    .last_touch (last_touch),
    .touch_cnt  (touch_cnt),
    .fault      (fault),
    .fault_c    (fault_c)
  );

  // Scorer-relative view of the scores; a saturated scorer wins outright.
  always_comb begin
    mine_c     = point_to ? score_pl2 : score_pl1;
    other_c    = point_to ? score_pl1 : score_pl2;
    mine_inc_c = mine_c + SCORE_W'(1);
    won_c      = (mine_c == SCORE_MAX) ||
                 is_win(32'(mine_inc_c), 32'(other_c), WIN_SCORE, WIN_MARGIN);
  end

  // Next-state and output logic.
  always_comb begin
    logic award;
    state_nxt      = state;
    dly_cnt_nxt    = dly_cnt;
    score_pl1_nxt  = score_pl1;
    score_pl2_nxt  = score_pl2;
    serve_req_nxt  = 1'b0;
    serve_side_nxt = serve_side;
    winner_nxt     = winner;
    point_to_nxt   = point_to;
    touch_clr_c    = 1'b0;
    award          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          score_pl1_nxt  = '0;
          score_pl2_nxt  = '0;
          serve_side_nxt = PLAYER_1;
          winner_nxt     = 1'b0;
          dly_cnt_nxt    = '0;
          state_nxt      = ST_SERVE_WAIT;
        end
      end
      ST_SERVE_WAIT: begin
        if (dly_cnt == DLY_LAST) begin
          serve_req_nxt = 1'b1;
          touch_clr_c   = 1'b1;
          state_nxt     = ST_RALLY;
        end else begin
          dly_cnt_nxt = dly_cnt + CNT_W'(1);
        end
      end
      ST_RALLY: begin
        if (gnd_edge_c) begin
          point_to_nxt = ~ball_side;
          state_nxt    = ST_POINT;
        end else if (fault_c) begin
          // A fault is always a repeat touch, so last_touch is the faulting side.
          point_to_nxt = ~last_touch;
          state_nxt    = ST_POINT;
        end
      end
      ST_POINT: begin
        dly_cnt_nxt = '0;
        state_nxt   = ST_SERVE_WAIT;
`ifdef RALLY_CTRL_SIDE_OUT_EN
        if (point_to == serve_side) begin
          award = 1'b1;
        end else begin
          serve_side_nxt = ~serve_side;
        end
`else
        award          = 1'b1;
        serve_side_nxt = point_to;
`endif
        if (award) begin
          if (mine_c != SCORE_MAX) begin
            if (point_to) begin
              score_pl2_nxt = mine_inc_c;
            end else begin
              score_pl1_nxt = mine_inc_c;
            end
          end
          if (won_c) begin
            winner_nxt = point_to;
            state_nxt  = ST_GAME_OVER;
          end
        end
      end
      ST_GAME_OVER: begin
        if (start) begin
          score_pl1_nxt  = '0;
          score_pl2_nxt  = '0;
          serve_side_nxt = ~winner;
          winner_nxt     = 1'b0;
          dly_cnt_nxt    = '0;
          state_nxt      = ST_SERVE_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    game_active_nxt = (state_nxt == ST_SERVE_WAIT) || (state_nxt == ST_RALLY);
    endgame_nxt     = (state_nxt == ST_GAME_OVER);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      score_pl1   <= '0;
      score_pl2   <= '0;
      serve_req   <= 1'b0;
      serve_side  <= 1'b0;
      game_active <= 1'b0;
      endgame     <= 1'b0;
      winner      <= 1'b0;
      point_to    <= 1'b0;
      gnd_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      dly_cnt     <= dly_cnt_nxt;
      score_pl1   <= score_pl1_nxt;
      score_pl2   <= score_pl2_nxt;
      serve_req   <= serve_req_nxt;
      serve_side  <= serve_side_nxt;
      game_active <= game_active_nxt;
      endgame     <= endgame_nxt;
      winner      <= winner_nxt;
      point_to    <= point_to_nxt;
      gnd_q       <= gnd_col;
    end
  end

endmodule

// File: tb/tb_rally_ctrl.sv
// Directed bench for rally_ctrl with a short serve delay and a 3-point game
// (rally-point scoring build).
module tb_rally_ctrl;

  localparam int unsigned SCORE_W     = 4;
  localparam int unsigned WIN_SCORE   = 3;
  localparam int unsigned WIN_MARGIN  = 2;
  localparam int unsigned MAX_TOUCHES = 3;
  localparam int unsigned SERVE_DLY   = 8;

  logic               pclk = 1'b0;
  logic               rst;
  logic               start;
  logic               gnd_col;
  logic               ball_side;
  logic               pl1_col;
  logic               pl2_col;
  logic [SCORE_W-1:0] score_pl1;
  logic [SCORE_W-1:0] score_pl2;
  logic               serve_req;
  logic               serve_side;
  logic               last_touch;
  logic [1:0]         touch_cnt;
  logic               fault;
  logic               game_active;
  logic               endgame;
  logic               winner;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       pl1;
    logic       pl2;
    logic [1:0] exp_cnt;
    logic       exp_last;
    logic       exp_fault;
  } touch_vec_t;

  touch_vec_t tv[8];

  rally_ctrl #(
    .SCORE_W     (SCORE_W),
    .WIN_SCORE   (WIN_SCORE),
    .WIN_MARGIN  (WIN_MARGIN),
    .MAX_TOUCHES (MAX_TOUCHES),
    .SERVE_DLY   (SERVE_DLY)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .start       (start),
    .gnd_col     (gnd_col),
    .ball_side   (ball_side),
    .pl1_col     (pl1_col),
    .pl2_col     (pl2_col),
    .score_pl1   (score_pl1),
    .score_pl2   (score_pl2),
    .serve_req   (serve_req),
    .serve_side  (serve_side),
    .last_touch  (last_touch),
    .touch_cnt   (touch_cnt),
    .fault       (fault),
    .game_active (game_active),
    .endgame     (endgame),
    .winner      (winner)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wait_serve(output int cyc);
    cyc = 0;
    while (serve_req !== 1'b1 && cyc < 40) begin
      step(1);
      cyc++;
    end
    check("serve_req_arrives", 32'(serve_req), 1);
  endtask

  task automatic play_point(input logic side);
    int c;
    wait_serve(c);
    gnd_col   = 1'b1;
    ball_side = side;
    step(1);
    gnd_col = 1'b0;
    step(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_score_pl1"},   32'(score_pl1),   0);
    check({tag, "_score_pl2"},   32'(score_pl2),   0);
    check({tag, "_serve_req"},   32'(serve_req),   0);
    check({tag, "_serve_side"},  32'(serve_side),  0);
    check({tag, "_last_touch"},  32'(last_touch),  0);
    check({tag, "_touch_cnt"},   32'(touch_cnt),   0);
    check({tag, "_fault"},       32'(fault),       0);
    check({tag, "_game_active"}, 32'(game_active), 0);
    check({tag, "_endgame"},     32'(endgame),     0);
    check({tag, "_winner"},      32'(winner),      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // Touch sequence applied inside one rally, each touch a separate edge.
    tv[0] = '{pl1: 1'b1, pl2: 1'b0, exp_cnt: 2'd1, exp_last: 1'b0, exp_fault: 1'b0};
    tv[1] = '{pl1: 1'b1, pl2: 1'b0, exp_cnt: 2'd2, exp_last: 1'b0, exp_fault: 1'b0};
    tv[2] = '{pl1: 1'b0, pl2: 1'b1, exp_cnt: 2'd1, exp_last: 1'b1, exp_fault: 1'b0};
    tv[3] = '{pl1: 1'b1, pl2: 1'b0, exp_cnt: 2'd1, exp_last: 1'b0, exp_fault: 1'b0};
    tv[4] = '{pl1: 1'b1, pl2: 1'b0, exp_cnt: 2'd2, exp_last: 1'b0, exp_fault: 1'b0};
    tv[5] = '{pl1: 1'b1, pl2: 1'b1, exp_cnt: 2'd2, exp_last: 1'b0, exp_fault: 1'b0};
    tv[6] = '{pl1: 1'b1, pl2: 1'b0, exp_cnt: 2'd3, exp_last: 1'b0, exp_fault: 1'b0};
    tv[7] = '{pl1: 1'b1, pl2: 1'b0, exp_cnt: 2'd3, exp_last: 1'b0, exp_fault: 1'b1};

    rst       = 1'b1;
    start     = 1'b0;
    gnd_col   = 1'b0;
    ball_side = 1'b0;
    pl1_col   = 1'b0;
    pl2_col   = 1'b0;
    step(2);
    rst = 1'b0;
    check_all_zero("reset");

    step(3);
    check("idle_no_start_active", 32'(game_active), 0);

    // Start and serve delay.
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("start_game_active", 32'(game_active), 1);
    check("start_serve_req_low", 32'(serve_req), 0);
    wait_serve(c);
    check("serve_delay_cycles", c, 8);
    check("first_serve_side", 32'(serve_side), 0);
    check("serve_touch_cnt", 32'(touch_cnt), 0);
    step(1);
    check("serve_req_single_pulse", 32'(serve_req), 0);
    check("rally_game_active", 32'(game_active), 1);

    // Touch table; last row is the fourth consecutive player-1 touch.
    for (int i = 0; i < 8; i++) begin
      pl1_col = tv[i].pl1;
      pl2_col = tv[i].pl2;
      step(1);
      check($sformatf("touch%0d_cnt", i),   32'(touch_cnt),  32'(tv[i].exp_cnt));
      check($sformatf("touch%0d_last", i),  32'(last_touch), 32'(tv[i].exp_last));
      check($sformatf("touch%0d_fault", i), 32'(fault),      32'(tv[i].exp_fault));
      pl1_col = 1'b0;
      pl2_col = 1'b0;
      step(1);
    end
    check("fault_point_pl2", 32'(score_pl2), 1);
    check("fault_point_pl1", 32'(score_pl1), 0);
    check("fault_serve_side", 32'(serve_side), 1);
    check("fault_pulse_ended", 32'(fault), 0);
    check("fault_back_to_serve", 32'(game_active), 1);

    // Ground contact and a touch in the same cycle: only the point counts.
    wait_serve(c);
    check("serve2_side", 32'(serve_side), 1);
    gnd_col   = 1'b1;
    ball_side = 1'b0;
    pl1_col   = 1'b1;
    step(1);
    check("gnd_beats_touch_cnt", 32'(touch_cnt), 0);
    check("gnd_beats_touch_fault", 32'(fault), 0);
    gnd_col = 1'b0;
    pl1_col = 1'b0;
    step(1);
    check("gnd_point_pl2", 32'(score_pl2), 2);
    check("gnd_point_pl1", 32'(score_pl1), 0);

    // Player 1 climbs to 3:2 (no win yet), then 4:2 wins.
    play_point(1'b1);
    play_point(1'b1);
    check("score_2_2_pl1", 32'(score_pl1), 2);
    check("score_2_2_side", 32'(serve_side), 0);
    play_point(1'b1);
    check("score_3_2_pl1", 32'(score_pl1), 3);
    check("score_3_2_no_endgame", 32'(endgame), 0);
    check("score_3_2_active", 32'(game_active), 1);
    play_point(1'b1);
    check("win_score_pl1", 32'(score_pl1), 4);
    check("win_score_pl2", 32'(score_pl2), 2);
    check("win_endgame", 32'(endgame), 1);
    check("win_winner", 32'(winner), 0);
    check("win_inactive", 32'(game_active), 0);
    step(5);
    check("game_over_holds", 32'(endgame), 1);
    check("game_over_holds_score", 32'(score_pl1), 4);

    // Restart from GAME_OVER: loser serves first.
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("restart_pl1", 32'(score_pl1), 0);
    check("restart_pl2", 32'(score_pl2), 0);
    check("restart_serve_side", 32'(serve_side), 1);
    check("restart_endgame", 32'(endgame), 0);
    check("restart_active", 32'(game_active), 1);

    // Score something, touch, then reset mid-rally.
    play_point(1'b0);
    check("pre_reset_pl2", 32'(score_pl2), 1);
    wait_serve(c);
    pl2_col = 1'b1;
    step(1);
    pl2_col = 1'b0;
    check("pre_reset_cnt", 32'(touch_cnt), 1);
    check("pre_reset_last", 32'(last_touch), 1);
    rst = 1'b1;
    step(1);
    check_all_zero("midrally_reset");
    rst = 1'b0;
    step(12);
    check("post_reset_idle", 32'(game_active), 0);
    check("post_reset_no_serve", 32'(serve_req), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("post_reset_start", 32'(game_active), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
